spi_wb_master: RTL and testbench
================================

# spi_wb_master

SPI-slave to Wishbone-master bridge: turns framed SPI transactions from the Raspberry Pi Zero host into single 32-bit Wishbone read/write cycles. It sits directly upstream of the Wishbone register peripherals, such as the LED register, and drives their wb_* slave inputs. The bridge runs on the system clock and oversamples the SPI pins; no SPI-clock domain logic is used.

## Interface
- DATA_WIDTH, 32, Wishbone data width; only 32 is supported.
- ADDR_WIDTH, 32, Wishbone address width; only 32 is supported.
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT, 255, maximum clk cycles to wait for ack/err before a cycle is aborted.
- clk  in  1  system clock; must be at least 8x spi_sclk.
- rst  in  1  reset; asynchronous, active-low.
- spi_sclk  in  1  SPI clock, mode 0; asynchronous to clk.
- spi_cs_n  in  1  SPI chip select, active-low; asynchronous to clk.
- spi_mosi  in  1  host-to-bridge data, MSB first.
- spi_miso  out  1  bridge-to-host data, MSB first; 0 while spi_cs_n is high.
- wb_adr_o  out  ADDR_WIDTH  cycle address.
- wb_dat_o  out  DATA_WIDTH  write data.
- wb_dat_i  in  DATA_WIDTH  read data.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  SELECT_WIDTH  byte select; always all ones during a cycle.
- wb_stb_o  out  1  strobe.
- wb_cyc_o  out  1  cycle; identical to wb_stb_o.
- wb_ack_i  in  1  acknowledge.
- wb_err_i  in  1  error.

## Operation
- SPI input synchronisation:
  - spi_sclk, spi_cs_n and spi_mosi each pass through a 2-flop synchroniser.
  - sclk rise/fall and cs fall/rise are edge-detected from the synchronised values.
  - mosi is sampled on a detected sclk rise.
- Frame format, all fields big-endian:
  - Write: cmd byte, 4 address bytes, 4 data bytes.
  - Read: cmd byte, 4 address bytes, 1 dummy byte, then 4 data bytes shifted out on miso.
- Command encoding:
  - 0x01 = write; 0x02 = read.
  - Any other value = NOP: the remaining frame is ignored until cs rises.
- FSM states: IDLE, CMD, ADDR, WDATA, WB_WR, DUMMY, RDATA, DRAIN.
  - IDLE -> CMD on cs fall.
  - CMD -> ADDR after 8 bits with a valid cmd; CMD -> DRAIN otherwise.
  - ADDR -> WDATA (write) or DUMMY (read) after 32 bits. For a read, the Wishbone read is issued at this transition.
  - WDATA -> WB_WR after 32 bits.
  - WB_WR -> DRAIN when the cycle terminates.
  - DUMMY -> RDATA after 8 bits.
  - RDATA -> DRAIN after 32 bits.
  - Any state -> IDLE on cs rise.
- Status byte, shifted out on miso during the CMD byte:
  - bit0 = last cycle terminated by err or timeout.
  - bit1 = a Wishbone cycle is still in progress.
  - bits 7:2 = 0.
  - bit0 clears after it has been reported.
- Wishbone cycle rules:
  - One outstanding cycle at a time.
  - stb, cyc, adr, dat_o and we are held stable until ack or err is sampled high, or until TIMEOUT cycles have elapsed.
  - err or timeout sets the error flag. A read that terminates this way returns 0xDEADBEEF.
- Read data:
  - Latched on ack.
  - If the read has not terminated at the first sclk fall of RDATA, 0xDEADBEEF is shifted out and the error flag is set. The late ack is still absorbed when it arrives.
- cs rise mid-frame:
  - Partially received bytes are discarded and no new cycle is issued.
  - A Wishbone cycle already issued runs to ack, err or timeout. A new frame's command is ignored (treated as NOP) while bit1 is set.
- Reset values:
  - spi_miso = 0; wb_stb_o = wb_cyc_o = wb_we_o = 0; wb_sel_o = 0.
  - wb_adr_o = 0; wb_dat_o = 0.
  - Error flag = 0; FSM = IDLE.

## Timing
- Edge detection occurs 3 clk after the pin transition (2 synchroniser flops plus 1 edge register).
- miso:
  - MSB of the status byte is valid 3 clk after cs falls.
  - Each subsequent bit changes 1 clk after a detected sclk fall.
- Write: wb_stb_o/wb_cyc_o rise 1 clk after the detected sclk rise of the final data bit.
- Read: wb_stb_o/wb_cyc_o rise 1 clk after the detected sclk rise of the final address bit.
- Cycle termination:
  - stb/cyc fall on the clk edge following the cycle in which ack or err is sampled high; no back-to-back cycles.
  - On timeout, stb/cyc fall after TIMEOUT clk.
- Read budget: the slave has the 8-bit dummy byte, about 8 sclk periods (at least 64 clk), to respond.

## Test plan
- Write frame 01 00000000 0000007F: wb_adr_o=0, wb_dat_o=0x7F, we=1, sel=0xF; slave acks after 1 clk; stb drops on the next clk; the next frame's status byte reads 0x00.
- Read frame 02 00000000 + dummy + 4 bytes, slave returns 0x12345678 with ack after 2 clk: miso carries 12 34 56 78; we=0 throughout.
- Slave never acks on a write, TIMEOUT=255: stb/cyc drop after exactly 255 clk; the next frame's status byte reads 0x01, and the frame after that reads 0x00.
- Slave asserts wb_err_i on a read: miso returns DE AD BE EF; the next status byte reads 0x01.
- cs rises after the 2nd address byte of a write: no stb ever asserts; a following valid write completes normally.
- Assert rst low asynchronously mid-cycle (stb high): stb, cyc and miso go 0 immediately without a clk edge; after rst is released, a fresh write frame completes.

Source files
------------

// File: rtl/spi_wb_master_if.sv
// Wishbone bus between the SPI bridge (master) and register peripherals (slave).
// Signal names are from the master's point of view:
//   wb_adr_o/wb_dat_o/wb_we_o/wb_sel_o/wb_stb_o/wb_cyc_o : master -> slave
//   wb_dat_i/wb_ack_i/wb_err_i                           : slave  -> master
interface spi_wb_master_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic                    wb_we_o;
  logic [SELECT_WIDTH-1:0] wb_sel_o;
  logic                    wb_stb_o;
  logic                    wb_cyc_o;
  logic                    wb_ack_i;
  logic                    wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/spi_wb_master.sv
// SPI-slave (mode 0) to Wishbone-master bridge. The SPI pins are oversampled
// on clk; each frame becomes at most one single 32-bit Wishbone cycle.
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   spi_sclk_i      SPI clock from host
//   spi_cs_n_i      SPI chip select, active-low
//   spi_mosi_i      host-to-bridge data, MSB first
//   spi_miso_o      bridge-to-host data, MSB first, 0 while cs is high
//   wb              Wishbone master port
//
// state | meaning
// IDLE  | waiting for cs fall
// CMD   | shifting in command byte, status byte goes out on miso
// ADDR  | shifting in 32-bit address
// WDATA | shifting in 32-bit write data
// WB_WR | write cycle on the bus, waiting for it to terminate
// DUMMY | read cycle issued, host clocks a dummy byte
// RDATA | shifting read data out on miso
// DRAIN | frame done or ignored, waiting for cs rise
module spi_wb_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_mosi_i,
  output logic              spi_miso_o,
  spi_wb_master_if.master   wb
);
  localparam logic [7:0]            CMD_WR   = 8'h01;
  localparam logic [7:0]            CMD_RD   = 8'h02;
  localparam logic [DATA_WIDTH-1:0] BAD_DATA = 32'hDEADBEEF;
  localparam int                    TW       = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, WB_WR, DUMMY, RDATA, DRAIN} state_t;
  state_t state_q, state_d;

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;

  logic [5:0]            bit_cnt_q;
  logic [5:0]            bits_last;
  logic                  last_bit;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q;
  logic                  cmd_wr_q;
  logic                  start_cyc;

  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q, rdata_q;
  logic                  stb_q, we_q, err_q, rd_done_q;
  logic [TW-1:0]         tmr_q;
  logic                  wb_end, wb_fail, late_rd, status_load;

  // cs syncs reset to "deselected" so leaving reset never looks like a cs fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
      cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
    end
  end

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
  assign cs_fall   = ~cs_sync_q[1] & cs_prev_q;
  assign cs_rise   = cs_sync_q[1] & ~cs_prev_q;
  assign rx_d      = {rx_q[DATA_WIDTH-2:0], mosi_sync_q[1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_cyc = 1'b0;
    bits_last = ((state_q == CMD) || (state_q == DUMMY)) ? 6'd7 : 6'd31;
    last_bit  = sclk_rise && (bit_cnt_q == bits_last);
    case (state_q)
      IDLE:  if (cs_fall) state_d = CMD;
      CMD:   if (last_bit) begin
               // a command arriving while a cycle is still running is a NOP
               if (((rx_d[7:0] == CMD_WR) || (rx_d[7:0] == CMD_RD)) && !stb_q) state_d = ADDR;
               else state_d = DRAIN;
             end
      ADDR:  if (last_bit) begin
               if (cmd_wr_q) state_d = WDATA;
               else begin
                 state_d   = DUMMY;
                 start_cyc = 1'b1;
               end
             end
      WDATA: if (last_bit) begin
               state_d   = WB_WR;
               start_cyc = 1'b1;
             end
      WB_WR: if (!stb_q) state_d = DRAIN;
      DUMMY: if (last_bit) state_d = RDATA;
      RDATA: if (last_bit) state_d = DRAIN;
      DRAIN: state_d = DRAIN;
      default: state_d = IDLE;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  assign wb_end      = stb_q && (wb.wb_ack_i || wb.wb_err_i || (tmr_q == '0));
  assign wb_fail     = stb_q && !wb.wb_ack_i && (wb.wb_err_i || (tmr_q == '0));
  // first sclk fall of RDATA is when the MSB must be on miso
  assign late_rd     = sclk_fall && (state_q == RDATA) && (bit_cnt_q == 6'd0);
  assign status_load = (state_q == IDLE) && cs_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_wr_q  <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rdata_q   <= '0;
      stb_q     <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rd_done_q <= 1'b0;
      tmr_q     <= '0;
    end else begin
      if (state_d != state_q) bit_cnt_q <= '0;
      else if (sclk_rise)     bit_cnt_q <= bit_cnt_q + 6'd1;
      if (sclk_rise) rx_q <= rx_d;
      if ((state_q == CMD) && last_bit)   cmd_wr_q <= (rx_d[7:0] == CMD_WR);
      if ((state_q == ADDR) && last_bit)  adr_q    <= rx_d;
      if ((state_q == WDATA) && last_bit) dat_q    <= rx_d;

      if (status_load)
        tx_q <= {6'b0, stb_q, err_q, 24'h0};
      else if (late_rd)
        tx_q <= rd_done_q ? rdata_q : BAD_DATA;
      else if (sclk_fall)
        tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};

      // a new error wins over clearing the one just reported
      if (wb_fail || (late_rd && !rd_done_q)) err_q <= 1'b1;
      else if (status_load)                   err_q <= 1'b0;

      if (start_cyc) begin
        stb_q     <= 1'b1;
        we_q      <= (state_q == WDATA);
        tmr_q     <= TW'(TIMEOUT - 1);
        rd_done_q <= 1'b0;
      end else if (wb_end) begin
        stb_q <= 1'b0;
        we_q  <= 1'b0;
        if (!we_q) begin
          rd_done_q <= 1'b1;
          rdata_q   <= wb.wb_ack_i ? wb.wb_dat_i : BAD_DATA;
        end
      end else if (stb_q) begin
        tmr_q <= tmr_q - TW'(1);
      end
    end
  end

  assign spi_miso_o  = ~spi_cs_n_i & (state_q != IDLE) & tx_q[DATA_WIDTH-1];
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = {SELECT_WIDTH{stb_q}};
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_cyc_o = stb_q;
endmodule

// File: tb/tb_spi_wb_master.sv
module tb_spi_wb_master;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n, sclk, cs_n, mosi, miso;
  always #5 clk = ~clk;

  spi_wb_master_if wb();

  spi_wb_master #(.TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk_i(sclk), .spi_cs_n_i(cs_n),
    .spi_mosi_i(mosi), .spi_miso_o(miso), .wb(wb)
  );

  int checks = 0;
  int errors = 0;

  // slave behaviour: 0 = ack after ack_dly, 1 = never respond, 2 = err after ack_dly
  int          slave_mode = 0;
  int          ack_dly = 1;
  logic [31:0] rd_value = 32'h0;

  int          stb_cnt = 0, last_len = 0, n_cycles = 0, we_hi_cnt = 0;
  logic [31:0] cap_adr, cap_dat;
  logic [3:0]  cap_sel;
  logic        cap_we, cap_cyc;

  always @(negedge clk) begin
    wb.wb_dat_i = rd_value;
    if (wb.wb_we_o) we_hi_cnt = we_hi_cnt + 1;
    if (wb.wb_stb_o) begin
      stb_cnt = stb_cnt + 1;
      if (stb_cnt == 1) n_cycles = n_cycles + 1;
      cap_adr = wb.wb_adr_o;
      cap_dat = wb.wb_dat_o;
      cap_sel = wb.wb_sel_o;
      cap_we  = wb.wb_we_o;
      cap_cyc = wb.wb_cyc_o;
      wb.wb_ack_i = (slave_mode == 0) && (stb_cnt == ack_dly);
      wb.wb_err_i = (slave_mode == 2) && (stb_cnt == ack_dly);
    end else begin
      if (stb_cnt != 0) last_len = stb_cnt;
      stb_cnt = 0;
      wb.wb_ack_i = 1'b0;
      wb.wb_err_i = 1'b0;
    end
  end

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      mosi = tx[i];
      repeat (HALF - 1) @(negedge clk);
      sclk  = 1'b1;
      rx[i] = miso;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_word(input logic [31:0] tx, output logic [31:0] rx);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      spi_byte(tx[i*8 +: 8], b);
      rx[i*8 +: 8] = b;
    end
  endtask

  task automatic cs_begin();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic wait_wb_idle(input int bound);
    int n = 0;
    while (wb.wb_stb_o && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wb.wb_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL wb_idle_wait: stb still %b after %0d clk, expected 0", wb.wb_stb_o, bound);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [31:0] d, output logic [7:0] st);
    logic [31:0] dummy;
    cs_begin();
    spi_byte(8'h01, st);
    spi_word(a, dummy);
    spi_word(d, dummy);
    cs_end();
  endtask

  task automatic read_frame(input logic [31:0] a, output logic [7:0] st, output logic [31:0] rd);
    logic [31:0] dummy;
    logic [7:0]  db;
    cs_begin();
    spi_byte(8'h02, st);
    spi_word(a, dummy);
    spi_byte(8'h00, db);
    spi_word(32'h0, rd);
    cs_end();
  endtask

  task automatic nop_frame(output logic [7:0] st);
    cs_begin();
    spi_byte(8'h00, st);
    cs_end();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    slave_mode = 0; ack_dly = 1; rd_value = 32'h0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (wb.wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", wb.wb_stb_o); end
    checks++; if (wb.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", wb.wb_cyc_o); end
    checks++; if (wb.wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", wb.wb_we_o); end
    checks++; if (wb.wb_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h expected 0", wb.wb_sel_o); end
    checks++; if (wb.wb_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h expected 0", wb.wb_adr_o); end
    checks++; if (wb.wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", wb.wb_dat_o); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
  endtask

  task automatic test_write();
    logic [7:0] st;
    int n0 = n_cycles;
    slave_mode = 0; ack_dly = 1;
    write_frame(32'h0, 32'h0000_007F, st);
    wait_wb_idle(100);
    checks++; if (st !== 8'h00) begin errors++; $display("FAIL write_status: got %h expected 00", st); end
    checks++; if (n_cycles - n0 !== 1) begin errors++; $display("FAIL write_ncyc: got %0d expected 1", n_cycles - n0); end
    checks++; if (cap_adr !== 32'h0) begin errors++; $display("FAIL write_adr: got %h expected 0", cap_adr); end
    checks++; if (cap_dat !== 32'h7F) begin errors++; $display("FAIL write_dat: got %h expected 7f", cap_dat); end
    checks++; if (cap_we !== 1'b1) begin errors++; $display("FAIL write_we: got %b expected 1", cap_we); end
    checks++; if (cap_sel !== 4'hF) begin errors++; $display("FAIL write_sel: got %h expected f", cap_sel); end
    checks++; if (cap_cyc !== 1'b1) begin errors++; $display("FAIL write_cyc: got %b expected 1", cap_cyc); end
    checks++; if (last_len !== 1) begin errors++; $display("FAIL write_stb_len: got %0d expected 1", last_len); end
  endtask

  task automatic test_read();
    logic [7:0]  st;
    logic [31:0] rd;
    int w0 = we_hi_cnt;
    slave_mode = 0; ack_dly = 2; rd_value = 32'h1234_5678;
    read_frame(32'h0000_0010, st, rd);
    wait_wb_idle(100);
    checks++; if (st !== 8'h00) begin errors++; $display("FAIL read_status: got %h expected 00", st); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL read_data: got %h expected 12345678", rd); end
    checks++; if (we_hi_cnt !== w0) begin errors++; $display("FAIL read_we: we high %0d clk, expected 0", we_hi_cnt - w0); end
    checks++; if (cap_adr !== 32'h10) begin errors++; $display("FAIL read_adr: got %h expected 10", cap_adr); end
    checks++; if (last_len !== 2) begin errors++; $display("FAIL read_stb_len: got %0d expected 2", last_len); end
  endtask

  task automatic test_timeout();
    logic [7:0] st;
    slave_mode = 1;
    write_frame(32'h0000_0004, 32'hA5A5_A5A5, st);
    nop_frame(st);
    checks++; if (st !== 8'h02) begin errors++; $display("FAIL timeout_busy_status: got %h expected 02", st); end
    wait_wb_idle(600);
    checks++; if (last_len !== 255) begin errors++; $display("FAIL timeout_stb_len: got %0d expected 255", last_len); end
    checks++; if (cap_dat !== 32'hA5A5_A5A5) begin errors++; $display("FAIL timeout_dat: got %h expected a5a5a5a5", cap_dat); end
    nop_frame(st);
    checks++; if (st !== 8'h01) begin errors++; $display("FAIL timeout_status1: got %h expected 01", st); end
    nop_frame(st);
    checks++; if (st !== 8'h00) begin errors++; $display("FAIL timeout_status2: got %h expected 00", st); end
  endtask

  task automatic test_read_err();
    logic [7:0]  st;
    logic [31:0] rd;
    slave_mode = 2; ack_dly = 1; rd_value = 32'h1111_2222;
    read_frame(32'h0000_0020, st, rd);
    wait_wb_idle(100);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_err_data: got %h expected deadbeef", rd); end
    checks++; if (last_len !== 1) begin errors++; $display("FAIL read_err_stb_len: got %0d expected 1", last_len); end
    nop_frame(st);
    checks++; if (st !== 8'h01) begin errors++; $display("FAIL read_err_status: got %h expected 01", st); end
    nop_frame(st);
  endtask

  task automatic test_abort();
    logic [7:0] st, b;
    int n0 = n_cycles;
    slave_mode = 0; ack_dly = 1;
    cs_begin();
    spi_byte(8'h01, st);
    spi_byte(8'h00, b);
    spi_byte(8'h00, b);
    cs_end();
    repeat (50) @(negedge clk);
    checks++; if (n_cycles !== n0) begin errors++; $display("FAIL abort_no_cycle: got %0d cycles expected 0", n_cycles - n0); end
    write_frame(32'h0000_0008, 32'hCAFE_F00D, st);
    wait_wb_idle(100);
    checks++; if (st !== 8'h00) begin errors++; $display("FAIL abort_status: got %h expected 00", st); end
    checks++; if (n_cycles - n0 !== 1) begin errors++; $display("FAIL abort_next_ncyc: got %0d expected 1", n_cycles - n0); end
    checks++; if (cap_adr !== 32'h8) begin errors++; $display("FAIL abort_next_adr: got %h expected 8", cap_adr); end
    checks++; if (cap_dat !== 32'hCAFE_F00D) begin errors++; $display("FAIL abort_next_dat: got %h expected cafef00d", cap_dat); end
  endtask

  task automatic test_async_reset();
    logic [7:0]  st;
    logic [31:0] dummy;
    int n0;
    slave_mode = 1;
    cs_begin();
    spi_byte(8'h01, st);
    spi_word(32'h0000_000C, dummy);
    spi_word(32'h1122_3344, dummy);
    checks++; if (wb.wb_stb_o !== 1'b1) begin errors++; $display("FAIL arst_stb_before: got %b expected 1", wb.wb_stb_o); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb.wb_stb_o !== 1'b0) begin errors++; $display("FAIL arst_stb: got %b expected 0", wb.wb_stb_o); end
    checks++; if (wb.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL arst_cyc: got %b expected 0", wb.wb_cyc_o); end
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL arst_miso: got %b expected 0", miso); end
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    slave_mode = 0; ack_dly = 1;
    n0 = n_cycles;
    write_frame(32'h0000_000C, 32'h55AA_55AA, st);
    wait_wb_idle(100);
    checks++; if (st !== 8'h00) begin errors++; $display("FAIL arst_status: got %h expected 00", st); end
    checks++; if (n_cycles - n0 !== 1) begin errors++; $display("FAIL arst_ncyc: got %0d expected 1", n_cycles - n0); end
    checks++; if (cap_dat !== 32'h55AA_55AA) begin errors++; $display("FAIL arst_dat: got %h expected 55aa55aa", cap_dat); end
    checks++; if (last_len !== 1) begin errors++; $display("FAIL arst_stb_len: got %0d expected 1", last_len); end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_read_err();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
